// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks BOOT -> FETCH -> HOLD, computes the next PC
// on consume, and latches into a sticky ERR state on imem timeout or misaligned target.
module fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int               MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [WIDTH-1:0] PC,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             fetch_err
);

  localparam int             CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t            state_r;
  logic              boot_done_r;
  logic [CW-1:0]     wait_cnt_r;
  logic [WIDTH-1:0]  next_pc_s;
  logic              consume_s;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  assign imem_addr = PC;

  // Branch target or sequential successor of the held instruction, wrapping modulo 2^WIDTH.
  always_comb begin
    next_pc_s = instr_pc + WIDTH'(4);
    consume_s = 1'b0;
    if (state_r == HOLD) begin
      consume_s = !stall;
    end else begin
      consume_s = 1'b0;
    end
    if (PCsrc) begin
      next_pc_s = instr_pc + ImmOp;
    end else begin
      next_pc_s = instr_pc + WIDTH'(4);
    end
  end

  // Fetch state machine; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= BOOT;
      boot_done_r <= 1'b0;
      wait_cnt_r  <= '0;
      PC          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      case (state_r)
        // BOOT spans one full clock after reset release before the first request.
        BOOT: begin
          if (!boot_done_r) begin
            boot_done_r <= 1'b1;
          end else begin
            state_r    <= FETCH;
            imem_req   <= 1'b1;
            wait_cnt_r <= '0;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= PC;
            state_r     <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r   <= ERR;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        HOLD: begin
          if (consume_s) begin
            PC          <= next_pc_s;
            instr_valid <= 1'b0;
            if (is_misaligned(next_pc_s)) begin
              state_r   <= ERR;
              fetch_err <= 1'b1;
            end else begin
              state_r    <= FETCH;
              imem_req   <= 1'b1;
              wait_cnt_r <= '0;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        ERR: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
        default: begin
          state_r     <= ERR;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main fetch/branch flow plus
// hand-written sequences for stall, wrap, misalign, async reset and timeout.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .ImmOp(ImmOp), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .PC(PC), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] imm;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_err;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_instr,
                         input logic [31:0] e_ipc, input logic e_err);
    chk({tag, ".imem_req"},    {31'd0, imem_req},    {31'd0, e_req});
    chk({tag, ".imem_addr"},   imem_addr,            e_addr);
    chk({tag, ".PC"},          PC,                   e_addr);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
    chk({tag, ".instr"},       instr,                e_instr);
    chk({tag, ".instr_pc"},    instr_pc,             e_ipc);
    chk({tag, ".fetch_err"},   {31'd0, fetch_err},   {31'd0, e_err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse rst between clock edges with imem_ack high; reset must act without a clock edge.
  task automatic do_reset(input string tag);
    #3;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_0000;
    rst        = 1'b1;
    #1;
    chk_all({tag, ".async"}, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk_all({tag, ".held"}, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst      = 1'b0;
    imem_ack = 1'b0;
    stall    = 1'b0;
    PCsrc    = 1'b0;
    ImmOp    = 32'h0;
  endtask

  task automatic boot_seq(input string tag);
    step();
    chk({tag, ".boot_req"}, {31'd0, imem_req}, 32'd0);
    step();
    chk({tag, ".first_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, ".first_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b0; PCsrc = 1'b0; ImmOp = 32'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    //        stall pcsrc imm            ack   rdata          req   addr           valid instr          ipc            err
    vt[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0000, 32'h0000_0000, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b0, 32'hA000_0000, 32'h0000_0000, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0004, 1'b0, 32'h0000_0004, 1'b1, 32'hA000_0004, 32'h0000_0004, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008, 1'b0, 32'hA000_0004, 32'h0000_0004, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0008, 1'b0, 32'h0000_0008, 1'b1, 32'hA000_0008, 32'h0000_0008, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_000C, 1'b0, 32'hA000_0008, 32'h0000_0008, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'hA000_000C, 1'b0, 32'h0000_000C, 1'b1, 32'hA000_000C, 32'h0000_000C, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 32'hA000_000C, 32'h0000_000C, 1'b0};
    vt[10] = '{1'b0, 1'b0, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0, 32'hA000_000C, 32'h0000_000C, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0010, 1'b0, 32'h0000_0010, 1'b1, 32'hA000_0010, 32'h0000_0010, 1'b0};
    vt[12] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008, 1'b0, 32'hA000_0010, 32'h0000_0010, 1'b0};
    vt[13] = '{1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008, 1'b0, 32'hA000_0010, 32'h0000_0010, 1'b0};
    vt[14] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hB000_0008, 1'b0, 32'h0000_0008, 1'b1, 32'hB000_0008, 32'h0000_0008, 1'b0};

    do_reset("rst0");

    for (int i = 0; i < 15; i++) begin
      stall      = vt[i].stall;
      PCsrc      = vt[i].pcsrc;
      ImmOp      = vt[i].imm;
      imem_ack   = vt[i].ack;
      imem_rdata = vt[i].rdata;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
              vt[i].e_instr, vt[i].e_ipc, vt[i].e_err);
    end

    // Stall for 5 cycles: held instruction stable, no request, PC frozen.
    imem_ack = 1'b0;
    stall    = 1'b1;
    PCsrc    = 1'b1;
    ImmOp    = 32'h0000_0040;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("stall%0d", i), 1'b0, 32'h8, 1'b1, 32'hB000_0008, 32'h8, 1'b0);
    end
    stall = 1'b0;
    PCsrc = 1'b0;
    step();
    chk_all("stall_release", 1'b1, 32'hC, 1'b0, 32'hB000_0008, 32'h8, 1'b0);

    // Branch to the top of the address space, then wrap to zero.
    imem_ack = 1'b1; imem_rdata = 32'hC000_000C;
    step();
    chk_all("wrap_hold", 1'b0, 32'hC, 1'b1, 32'hC000_000C, 32'hC, 1'b0);
    imem_ack = 1'b0; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF0;
    step();
    chk_all("wrap_br", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hC000_000C, 32'hC, 1'b0);
    PCsrc = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hD000_0000;
    step();
    chk_all("wrap_top", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hD000_0000, 32'hFFFF_FFFC, 1'b0);
    imem_ack = 1'b0;
    step();
    chk_all("wrap_zero", 1'b1, 32'h0, 1'b0, 32'hD000_0000, 32'hFFFF_FFFC, 1'b0);

    // Misaligned branch target: PC loads, error latches, no further requests.
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    step();
    chk_all("mis_hold", 1'b0, 32'h0, 1'b1, 32'hE000_0000, 32'h0, 1'b0);
    imem_ack = 1'b0; PCsrc = 1'b1; ImmOp = 32'h0000_0006;
    step();
    chk_all("mis_err", 1'b0, 32'h6, 1'b0, 32'hE000_0000, 32'h0, 1'b1);
    PCsrc = 1'b0; imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("mis_stay%0d", i), 1'b0, 32'h6, 1'b0, 32'hE000_0000, 32'h0, 1'b1);
    end

    // Reset clears the sticky error; then reset again while waiting in FETCH.
    do_reset("rst_err");
    boot_seq("b1");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wait_req%0d", i), {31'd0, imem_req}, 32'd1);
    end
    do_reset("rst_mid");

    // Timeout: 15 FETCH cycles without ack.
    boot_seq("b2");
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("to_wait%0d", i), {30'd0, imem_req, fetch_err}, 32'd2);
    end
    step();
    chk("to_err", {30'd0, imem_req, fetch_err}, 32'd1);
    imem_ack = 1'b1;
    step();
    chk("to_after", {30'd0, imem_req, fetch_err}, 32'd1);
    chk("to_valid", {31'd0, instr_valid}, 32'd0);
    do_reset("rst_to");

    // Ack arriving in the 15th wait cycle still completes the fetch.
    boot_seq("b3");
    for (int i = 0; i < 14; i++) begin
      step();
    end
    chk("late_pre", {30'd0, imem_req, fetch_err}, 32'd2);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    chk_all("late_ack", 1'b0, 32'h0, 1'b1, 32'h1234_5678, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
